// File: rtl/register_to_uart_pkg.sv
// Shared ASCII constants and nibble-to-hex-character conversion for the
// register_to_uart debug dump.
package register_to_uart_pkg;

   typedef logic [7:0] ascii_t;

   localparam ascii_t ASC_0     = 8'h30;
   localparam ascii_t ASC_A_M10 = 8'h37;
   localparam ascii_t ASC_CR    = 8'h0D;
   localparam ascii_t ASC_LF    = 8'h0A;

   // 'A' minus ten, so that adding the raw nibble value lands on 'A'..'F'
   function automatic ascii_t hex2ascii(input logic [3:0] nibble);
      if (nibble < 4'd10)
         return ASC_0 + {4'b0000, nibble};
      else
         return ASC_A_M10 + {4'b0000, nibble};
   endfunction

endpackage

// File: rtl/register_to_uart_hex_nibble_to_ascii.sv
// Combinational conversion of one 4-bit nibble into its uppercase ASCII hex
// character.
module hex_nibble_to_ascii
   import register_to_uart_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [7:0] o_ascii
);

   assign o_ascii = hex2ascii(i_nibble);

endmodule

// File: rtl/register_to_uart.sv
// Serialises a wide register as ASCII hex (MSB nibble first, optional CR LF),
// one character per rising edge of uart_ready, repeating frames forever.
module register_to_uart
   import register_to_uart_pkg::*;
#(
   parameter int WIDTH    = 96,
   parameter int ADD_CRLF = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data,
   input  logic             uart_ready,
   output logic [7:0]       tx_data
);

   localparam int NDIG = WIDTH / 4;
   localparam int FLEN = NDIG + 2 * ADD_CRLF;
   // One extra count of headroom so NDIG itself is always representable
   localparam int IW   = $clog2(FLEN + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(FLEN - 1);
   localparam logic [IW-1:0] NDIG_IDX = IW'(NDIG);

   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_snap;
   logic             r_rdyQ;
   logic             w_advance;
   logic [3:0]       w_nibble;
   logic [7:0]       w_ascii;

   assign w_advance = uart_ready & ~r_rdyQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdyQ <= 1'b0;
      end else begin
         r_rdyQ <= uart_ready;
      end
   end

   // Snapshot follows live data only while parked on the first character, so
   // each frame prints a single coherent sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap <= '0;
      end else if ((r_idx == '0) && !w_advance) begin
         r_snap <= data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_advance) begin
         r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
   end

   always_comb begin
      w_nibble = '0;
      for (int k = 0; k < NDIG; k++) begin
         if (r_idx == IW'(k)) begin
            w_nibble = r_snap[WIDTH-1-4*k -: 4];
         end
      end
   end

   hex_nibble_to_ascii u_hexNibble (
      .i_nibble (w_nibble),
      .o_ascii  (w_ascii)
   );

   // Output depends only on registered state, never on data or uart_ready
   always_comb begin
      tx_data = ASC_LF;
      if (r_idx < NDIG_IDX) begin
         tx_data = w_ascii;
      end else if (r_idx == NDIG_IDX) begin
         tx_data = ASC_CR;
      end
   end

endmodule

// File: tb/tb_register_to_uart.sv
// Directed self-checking bench for register_to_uart: a 96-bit CR/LF instance
// and an 8-bit digits-only instance sharing clock and reset.
module tb_register_to_uart;

   localparam logic [95:0] DATA_A = 96'h12_345678_9abc_def123456789;
   localparam logic [95:0] DATA_F = {96{1'b1}};

   logic        clk;
   logic        rst_n;
   logic [95:0] dataWide;
   logic        readyWide;
   logic [7:0]  txWide;
   logic [7:0]  dataNarrow;
   logic        readyNarrow;
   logic [7:0]  txNarrow;

   int checks;
   int failures;

   register_to_uart #(.WIDTH(96), .ADD_CRLF(1)) dutWide (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (dataWide),
      .uart_ready (readyWide),
      .tx_data    (txWide)
   );

   register_to_uart #(.WIDTH(8), .ADD_CRLF(0)) dutNarrow (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (dataNarrow),
      .uart_ready (readyNarrow),
      .tx_data    (txNarrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed character with its expected value
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One-clock ready pulse, then one quiet clock so the result has settled
   task automatic applyStimulus(input bit narrow);
      if (narrow) readyNarrow = 1'b1; else readyWide = 1'b1;
      @(negedge clk);
      readyNarrow = 1'b0;
      readyWide   = 1'b0;
      @(negedge clk);
   endtask

   // Hand-derived reference: hex digit characters, then CR, LF
   function automatic logic [7:0] expChar(input logic [95:0] d, input int i);
      logic [3:0] n;
      if (i == 24) return 8'h0D;
      if (i == 25) return 8'h0A;
      n = d[95-4*i -: 4];
      case (n)
         4'h0: return "0";  4'h1: return "1";  4'h2: return "2";  4'h3: return "3";
         4'h4: return "4";  4'h5: return "5";  4'h6: return "6";  4'h7: return "7";
         4'h8: return "8";  4'h9: return "9";  4'hA: return "A";  4'hB: return "B";
         4'hC: return "C";  4'hD: return "D";  4'hE: return "E";  default: return "F";
      endcase
   endfunction

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      dataWide    = DATA_A;
      readyWide   = 1'b0;
      dataNarrow  = 8'hA5;
      readyNarrow = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset_wide", txWide, 8'h30);
      checkOutput("reset_narrow", txNarrow, 8'h30);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("first_char", txWide, 8'h31);

      for (int i = 0; i < 26; i++) begin
         checkOutput($sformatf("frameA_%0d", i), txWide, expChar(DATA_A, i));
         applyStimulus(1'b0);
      end
      checkOutput("wrap", txWide, 8'h31);

      readyWide = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("hold_level", txWide, 8'h32);
      readyWide = 1'b0;
      @(negedge clk);
      checkOutput("hold_release", txWide, 8'h32);
      applyStimulus(1'b0);
      checkOutput("after_hold", txWide, 8'h33);

      dataWide = DATA_F;
      for (int i = 2; i < 26; i++) begin
         checkOutput($sformatf("frozen_%0d", i), txWide, expChar(DATA_A, i));
         applyStimulus(1'b0);
      end
      for (int i = 0; i < 26; i++) begin
         checkOutput($sformatf("frameF_%0d", i), txWide, expChar(DATA_F, i));
         applyStimulus(1'b0);
      end
      checkOutput("wrapF", txWide, 8'h46);

      dataWide = DATA_A;
      @(negedge clk);
      checkOutput("retrack", txWide, 8'h31);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0);
      checkOutput("idx10", txWide, 8'h42);

      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", txWide, 8'h30);
      @(negedge clk);
      checkOutput("held_reset", txWide, 8'h30);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("restart_d0", txWide, 8'h31);
      applyStimulus(1'b0);
      checkOutput("restart_d1", txWide, 8'h32);

      checkOutput("narrow_d0", txNarrow, 8'h41);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1);
         checkOutput($sformatf("narrow_%0d", i + 1), txNarrow,
                     (i % 2 == 0) ? 8'h35 : 8'h41);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
